// File: rtl/sakebi_eth_rx_framer.sv
// sakebi_eth_rx_framer
//   Turns the RMII receiver's byte stream (bytes after SFD, no TLAST) into
//   AXI-Stream frames. The frame end is found from a run of idle input cycles.
//   The 4-byte FCS is stripped and checked with CRC-32, and a per-frame error
//   flag is reported on TUSER of the last beat.
//
// Ports
//   i_axis_ACLK      clock; all logic is in this domain
//   i_axis_ARESET    asynchronous, active-high reset
//   i_s_axis_*       input byte stream; TREADY is tied high (no back-pressure)
//   o_m_axis_*       output frame stream; TUSER is meaningful only with TLAST
//   i_m_axis_TREADY  downstream ready
//   o_frame_cnt      good frames, saturating
//   o_err_cnt        bad frames (FCS, runt, overrun), saturating
module sakebi_eth_rx_framer #(
  parameter int GAP_CYCLES = 32,  // idle cycles that end a frame, 4..255
  parameter int DATA_WIDTH = 8    // fixed at 8
) (
  input  logic                  i_axis_ACLK,
  input  logic                  i_axis_ARESET,
  input  logic                  i_s_axis_TVALID,
  output logic                  o_s_axis_TREADY,
  input  logic [DATA_WIDTH-1:0] i_s_axis_TDATA,
  output logic                  o_m_axis_TVALID,
  input  logic                  i_m_axis_TREADY,
  output logic [DATA_WIDTH-1:0] o_m_axis_TDATA,
  output logic                  o_m_axis_TLAST,
  output logic                  o_m_axis_TUSER,
  output logic [15:0]           o_frame_cnt,
  output logic [15:0]           o_err_cnt
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [7:0]  GAP_LAST    = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_STREAM, ST_FLUSH} state_t;

  state_t                     state_reg;
  logic [3:0][DATA_WIDTH-1:0] win_reg;   // [0] newest byte, [3] oldest
  logic [3:0][DATA_WIDTH-1:0] win_next;
  logic [DATA_WIDTH-1:0]      pend_reg;  // oldest byte known not to be FCS
  logic [2:0]                 cnt_reg;
  logic [31:0]                crc_reg;
  logic [7:0]                 gap_reg;
  logic                       ovf_reg;

  logic                  beat;
  logic                  gap_end;
  logic                  out_hold;
  logic                  frame_bad;
  logic                  start_frame;
  logic [31:0]           crc_next;
  logic [31:0]           crc_first;
  logic                  emit;
  logic                  emit_last;
  logic                  emit_user;
  logic [DATA_WIDTH-1:0] emit_data;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [DATA_WIDTH-1:0] data);
    logic [31:0] c;
    c = crc_in ^ 32'(data);
    for (int i = 0; i < DATA_WIDTH; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  assign o_s_axis_TREADY = 1'b1;
  assign beat            = i_s_axis_TVALID;
  assign crc_next        = crc32_byte(crc_reg, i_s_axis_TDATA);
  assign crc_first       = crc32_byte(CRC_INIT, i_s_axis_TDATA);
  assign gap_end         = !beat && (gap_reg == GAP_LAST);
  assign out_hold        = o_m_axis_TVALID && !i_m_axis_TREADY;
  // A dropped FLUSH beat still counts the frame as bad.
  assign frame_bad       = (crc_reg != CRC_RESIDUE) || ovf_reg || out_hold;
  // A beat in the FLUSH cycle opens the next frame straight away.
  assign start_frame     = beat && (state_reg == ST_IDLE || state_reg == ST_FLUSH);

  // Window shift: the new byte enters at [0], everything else moves one older.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_win
      if (gi == 0) begin : g_new
        assign win_next[gi] = i_s_axis_TDATA;
      end else begin : g_old
        assign win_next[gi] = win_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    emit      = 1'b0;
    emit_data = pend_reg;
    emit_last = 1'b0;
    emit_user = 1'b0;
    if (state_reg == ST_STREAM && beat) begin
      emit = 1'b1;
    end
    if (state_reg == ST_FLUSH) begin
      emit      = 1'b1;
      emit_last = 1'b1;
      emit_user = frame_bad;
    end
  end

  always_ff @(posedge i_axis_ACLK or posedge i_axis_ARESET) begin
    if (i_axis_ARESET) begin
      state_reg       <= ST_IDLE;
      win_reg         <= '0;
      pend_reg        <= '0;
      cnt_reg         <= '0;
      crc_reg         <= '0;
      gap_reg         <= '0;
      ovf_reg         <= 1'b0;
      o_m_axis_TVALID <= 1'b0;
      o_m_axis_TDATA  <= '0;
      o_m_axis_TLAST  <= 1'b0;
      o_m_axis_TUSER  <= 1'b0;
      o_frame_cnt     <= '0;
      o_err_cnt       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
        end
        ST_FILL: begin
          if (beat) begin
            win_reg <= win_next;
            crc_reg <= crc_next;
            gap_reg <= '0;
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd4) begin
              pend_reg  <= win_reg[3];
              state_reg <= ST_STREAM;
            end
          end else if (gap_end) begin
            // Runt: four bytes or fewer, nothing was emitted.
            if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
            state_reg <= ST_IDLE;
          end else begin
            gap_reg <= gap_reg + 8'd1;
          end
        end
        ST_STREAM: begin
          if (beat) begin
            pend_reg <= win_reg[3];
            win_reg  <= win_next;
            crc_reg  <= crc_next;
            gap_reg  <= '0;
          end else if (gap_end) begin
            state_reg <= ST_FLUSH;
          end else begin
            gap_reg <= gap_reg + 8'd1;
          end
        end
        ST_FLUSH: begin
          if (frame_bad) begin
            if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
          end else begin
            if (o_frame_cnt != 16'hFFFF) o_frame_cnt <= o_frame_cnt + 16'd1;
          end
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (start_frame) begin
        win_reg    <= '0;
        win_reg[0] <= i_s_axis_TDATA;
        cnt_reg    <= 3'd1;
        crc_reg    <= crc_first;
        gap_reg    <= '0;
        ovf_reg    <= 1'b0;
        state_reg  <= ST_FILL;
      end

      // Single output register: a held beat wins over a new emit (which is
      // dropped and flagged); an accepted beat is replaced without loss.
      if (emit) begin
        if (out_hold) begin
          if (!emit_last) ovf_reg <= 1'b1;
        end else begin
          o_m_axis_TVALID <= 1'b1;
          o_m_axis_TDATA  <= emit_data;
          o_m_axis_TLAST  <= emit_last;
          o_m_axis_TUSER  <= emit_user;
        end
      end else if (o_m_axis_TVALID && i_m_axis_TREADY) begin
        o_m_axis_TVALID <= 1'b0;
        o_m_axis_TDATA  <= '0;
        o_m_axis_TLAST  <= 1'b0;
        o_m_axis_TUSER  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sakebi_eth_rx_framer.md
SAKEBI_ETH_RX_FRAMER -- requirements
Module: sakebi_eth_rx_framer

Interface
REQ-001 Parameter GAP_CYCLES, default 32: the number of consecutive idle input cycles that ends a frame; legal range 4..255.
REQ-002 Parameter DATA_WIDTH, default 8: byte width, fixed at 8; any other value is unsupported.
REQ-003 i_axis_ACLK  in  1  single clock; all logic is in this domain.
REQ-004 i_axis_ARESET  in  1  asynchronous, active-high reset.
REQ-005 i_s_axis_TVALID  in  1  input byte strobe from the RMII receiver (frame bytes after SFD, no TLAST).
REQ-006 o_s_axis_TREADY  out  1  tied high; the block never back-pressures its input.
REQ-007 i_s_axis_TDATA  in  8  input byte.
REQ-008 o_m_axis_TVALID  out  1  output beat valid.
REQ-009 i_m_axis_TREADY  in  1  downstream ready.
REQ-010 o_m_axis_TDATA  out  8  frame byte with FCS stripped.
REQ-011 o_m_axis_TLAST  out  1  marks the last byte of the frame.
REQ-012 o_m_axis_TUSER  out  1  frame-error flag; meaningful only when TLAST=1.
REQ-013 o_frame_cnt  out  16  count of good frames, saturating at 0xFFFF.
REQ-014 o_err_cnt  out  16  count of bad frames (FCS, runt or overrun), saturating at 0xFFFF.

Function
REQ-015 States: IDLE, FILL, STREAM, FLUSH; any illegal encoding returns to IDLE.
REQ-016 IDLE: an input beat loads the byte into a 4-byte FCS window, sets byte count to 1, reinitialises CRC to 0xFFFFFFFF with that byte applied, clears the gap counter and the frame error flag, and goes to FILL.
REQ-017 FILL: each input beat shifts into the window and increments the count; on the 5th byte the oldest window byte moves into a pending-byte register and the state goes to STREAM.
REQ-018 STREAM: each input beat emits the pending byte as a non-last output beat, moves the oldest window byte to pending and shifts the new byte in.
REQ-019 CRC: reflected CRC-32 (polynomial 0xEDB88320) is updated over every input byte, including the FCS, with byte-serial update in the same cycle; a frame is good only if the final register equals 0xDEBB20E3.
REQ-020 Gap counter: clears on every input beat; increments on each idle cycle in FILL or STREAM; end-of-frame is the idle cycle in which the count reaches GAP_CYCLES-1.
REQ-021 End-of-frame in FILL (frame of 4 bytes or fewer): the runt is discarded, no output beat is produced, o_err_cnt increments, and the state goes to IDLE.
REQ-022 End-of-frame in STREAM: go to FLUSH; FLUSH lasts one cycle and emits the pending byte with TLAST=1 and TUSER = (CRC bad OR overrun flag).
REQ-023 In the FLUSH cycle: o_frame_cnt increments if TUSER=0, otherwise o_err_cnt increments; then the state goes to IDLE.
REQ-024 An input beat in the FLUSH cycle is processed as the IDLE first-byte case (REQ-016), and the next state is FILL instead of IDLE.
REQ-025 The output is a single register; it loads on emit, and clears when TVALID&&TREADY with no simultaneous emit.
REQ-026 Emit while the register holds an unaccepted beat (TVALID=1, TREADY=0): the new byte is dropped, the held beat is kept unchanged, and the frame overrun flag is set.
REQ-027 Emit in the same cycle as an accepting handshake: the new beat replaces the old one with no loss.
REQ-028 Overrun of the FLUSH beat itself: the TLAST beat is dropped, and o_err_cnt still increments.
REQ-029 Output latency: a non-last byte appears on TDATA one cycle after the input beat that pushes it out; the TLAST beat appears one cycle after FLUSH.

Reset
REQ-030 While i_axis_ARESET is high: state is IDLE; o_m_axis_TVALID, TDATA, TLAST, TUSER are 0; both counters are 0; CRC, window, pending register, gap counter and flags are cleared.
REQ-031 Reset asserted mid-frame: the partial frame is abandoned with no TLAST emitted; the first input beat after release starts a new frame.

Verification
REQ-032 64-byte frame with correct FCS, one byte every 4 cycles, TREADY=1 -> 60 beats, TLAST and TUSER=0 on the 60th beat, o_frame_cnt=1, o_err_cnt=0.
REQ-033 Same frame with byte 10 XORed with 0x01 -> 60 beats, TUSER=1 on the last beat, o_err_cnt=1.
REQ-034 3-byte burst followed by idle -> no output beats, o_err_cnt=1.
REQ-035 TREADY=0 from byte 20 for 12 cycles -> overrun, bytes dropped, TLAST beat TUSER=1, o_err_cnt=1.
REQ-036 Two good frames separated by exactly GAP_CYCLES idle cycles, second frame's first byte in the FLUSH cycle -> two TLAST beats, o_frame_cnt=2.
REQ-037 Reset pulse at byte 30 of a frame, then a good 64-byte frame -> all outputs 0 during reset, 60 beats afterwards, o_frame_cnt=1.
